// File: rtl/sram_arb.sv
// Single-port SRAM arbiter: CPU/loader port A versus read-burst DMA port B.
// Optional B-wait statistics counter enabled by defining SRAM_ARB_STAT_EN.
module sram_arb #(
    parameter int unsigned AW         = 19,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic          FCLK,
    input  logic          RST_OX,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [7:0]    A_WDATA,
    output logic          A_GNT,
    output logic          A_RVALID,
    output logic [7:0]    A_RDATA,
    input  logic          B_REQ,
    input  logic [AW-1:0] B_ADDR,
    input  logic [7:0]    B_LEN,
    output logic          B_RVALID,
    output logic [7:0]    B_RDATA,
    output logic          B_DONE,
    output logic [AW-1:0] SRAM_A,
    output logic          SRAM_OE_X,
    output logic [7:0]    SRAM_DOUT,
`ifdef SRAM_ARB_STAT_EN
    output logic [15:0]   STAT_BWAIT,
`endif
    input  logic [7:0]    SRAM_DIN
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]    state_q;
    logic [AW-1:0] bptr_q;
    logic [7:0]    bcnt_q;
    logic [7:0]    starve_q;
    logic          last_b_q;
    logic          p_a_rd_q;
    logic          p_b_q;
    logic          p_b_last_q;

    logic          b_hold;
    logic          b_pending;
    logic          b_slot;
    logic          b_last;
    logic          a_gnt;
    logic          drop;
    logic [AW-1:0] b_addr;

    // A finished burst keeps B_REQ high until the requester has seen B_DONE;
    // hold off a new burst start until then.
    always_comb begin
        b_hold    = p_b_q | B_DONE;
        b_pending = B_REQ & ~b_hold;
        b_slot    = 1'b0;
        b_last    = 1'b0;
        b_addr    = bptr_q;
        a_gnt     = 1'b0;
        drop      = 1'b0;
        if (RST_OX) begin
            if (state_q == StIdle) begin
                b_slot = b_pending & (~A_REQ | (starve_q == 8'(STARVE_LIM)));
                b_addr = B_ADDR;
                b_last = (B_LEN == 8'd0);
            end else begin
                b_slot = B_REQ & ~(A_REQ & last_b_q);
                b_last = (bcnt_q == 8'd0);
                drop   = ~B_REQ;
            end
            a_gnt = A_REQ & ~b_slot;
        end
    end

    assign A_GNT = a_gnt;

    always_ff @(posedge FCLK or negedge RST_OX) begin
        if (!RST_OX) begin
            state_q    <= StIdle;
            bptr_q     <= '0;
            bcnt_q     <= 8'd0;
            starve_q   <= 8'd0;
            last_b_q   <= 1'b0;
            p_a_rd_q   <= 1'b0;
            p_b_q      <= 1'b0;
            p_b_last_q <= 1'b0;
            SRAM_A     <= '0;
            SRAM_OE_X  <= 1'b0;
            SRAM_DOUT  <= 8'd0;
            A_RVALID   <= 1'b0;
            A_RDATA    <= 8'd0;
            B_RVALID   <= 1'b0;
            B_RDATA    <= 8'd0;
            B_DONE     <= 1'b0;
        end else begin
            // The arbitration win in IDLE is itself the first burst slot.
            if (b_slot) begin
                bptr_q  <= b_addr + 1'b1;
                bcnt_q  <= (state_q == StIdle) ? (B_LEN - 8'd1) : (bcnt_q - 8'd1);
                state_q <= b_last ? StIdle : StBurst;
            end else if (drop) begin
                state_q <= StIdle;
            end

            if (b_slot) begin
                starve_q <= 8'd0;
            end else if (a_gnt && state_q == StIdle && b_pending &&
                         starve_q != 8'(STARVE_LIM)) begin
                starve_q <= starve_q + 8'd1;
            end

            if (b_slot) begin
                last_b_q <= 1'b1;
            end else if (a_gnt) begin
                last_b_q <= 1'b0;
            end

            if (a_gnt) begin
                SRAM_A    <= A_ADDR;
                SRAM_DOUT <= A_WDATA;
            end else if (b_slot) begin
                SRAM_A <= b_addr;
            end
            SRAM_OE_X <= a_gnt & A_WE;

            p_a_rd_q   <= a_gnt & ~A_WE;
            p_b_q      <= b_slot;
            p_b_last_q <= b_slot & b_last;

            A_RVALID <= p_a_rd_q;
            if (p_a_rd_q) begin
                A_RDATA <= SRAM_DIN;
            end
            B_RVALID <= p_b_q;
            if (p_b_q) begin
                B_RDATA <= SRAM_DIN;
            end
            // On an early drop, DONE rides with the byte still in flight, or alone.
            B_DONE <= p_b_last_q | drop;
        end
    end

`ifdef SRAM_ARB_STAT_EN
    logic b_want;

    always_comb begin
        b_want = (state_q == StBurst) ? B_REQ : b_pending;
    end

    always_ff @(posedge FCLK or negedge RST_OX) begin
        if (!RST_OX) begin
            STAT_BWAIT <= 16'd0;
        end else if (B_DONE) begin
            STAT_BWAIT <= 16'd0;
        end else if (b_want && !b_slot && STAT_BWAIT != 16'hFFFF) begin
            STAT_BWAIT <= STAT_BWAIT + 16'd1;
        end
    end
`endif

endmodule
